// File: rtl/is_pkg_uart_controller.sv
// Shared definitions for the UART controller slice: byte width, ASCII constants,
// hex-word transmitter state encoding and the nibble-to-ASCII mapping.
package is_pkg_uart_controller;

    localparam int unsigned DATA_W = 8;

    localparam logic [DATA_W-1:0] ASCII_CR = 8'h0D;
    localparam logic [DATA_W-1:0] ASCII_LF = 8'h0A;
    localparam logic [DATA_W-1:0] ASCII_0  = 8'h30;
    localparam logic [DATA_W-1:0] ASCII_X  = 8'h78;
    localparam logic [DATA_W-1:0] ASCII_A  = 8'h41;

    typedef enum logic [2:0] {
        IDLE,
        PFX0,
        PFX1,
        DIGIT,
        CR,
        LF
    } hex_tx_state_e;

    // Uppercase hex digit for one nibble.
    function automatic logic [DATA_W-1:0] nibble_to_ascii(input logic [3:0] nib);
        logic [DATA_W-1:0] n;
        n = {{(DATA_W-4){1'b0}}, nib};
        if (nib < 4'd10) begin
            return ASCII_0 + n;
        end
        return ASCII_A + n - DATA_W'(10);
    endfunction

endpackage

// File: rtl/is_uart_hex_word_tx.sv
// Prints one binary word per handshake as "0x" + hex digits (MSB first) + CR LF
// on a registered valid/ready byte stream feeding the UART transmitter.
import is_pkg_uart_controller::*;

module is_uart_hex_word_tx #(
    parameter int unsigned WORD_W    = 32,
    parameter bit          PREFIX_EN = 1'b1,
    parameter bit          EOL_EN    = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [WORD_W-1:0] word_i,
    input  logic              word_valid_i,
    output logic              word_ready_o,
    output logic [DATA_W-1:0] byte_data_o,
    output logic              byte_valid_o,
    input  logic              byte_ready_i,
    output logic              busy_o
);

    localparam int unsigned NIB_N = WORD_W / 4;
    localparam int unsigned CNT_W = (NIB_N > 1) ? $clog2(NIB_N) : 1;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(NIB_N - 1);

    if ((WORD_W % 4 != 0) || (WORD_W < 4)) begin : g_bad_word_w
        $error("WORD_W must be a multiple of 4 and at least 4");
    end

    hex_tx_state_e     state_q, state_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] byte_data_q, byte_data_d;
    logic              byte_valid_q, byte_valid_d;
    logic              xfer;

    assign xfer = byte_valid_q & byte_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            byte_data_q  <= '0;
            byte_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (word_valid_i) begin
                    shift_d = word_i;
                    cnt_d   = CNT_TOP;
                    state_d = PREFIX_EN ? PFX0 : DIGIT;
                end
            end
            PFX0:  if (xfer) state_d = PFX1;
            PFX1:  if (xfer) state_d = DIGIT;
            DIGIT: begin
                if (xfer) begin
                    shift_d = shift_q << 4;
                    // Exit on the last nibble so the counter never wraps.
                    if (cnt_q == '0) begin
                        state_d = EOL_EN ? CR : IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            CR:      if (xfer) state_d = LF;
            LF:      if (xfer) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Byte outputs are registered: derive them from the state being entered.
    always_comb begin
        byte_data_d  = '0;
        byte_valid_d = (state_d != IDLE);
        case (state_d)
            PFX0:    byte_data_d = ASCII_0;
            PFX1:    byte_data_d = ASCII_X;
            DIGIT:   byte_data_d = nibble_to_ascii(shift_d[WORD_W-1 -: 4]);
            CR:      byte_data_d = ASCII_CR;
            LF:      byte_data_d = ASCII_LF;
            default: byte_data_d = '0;
        endcase
    end

    assign word_ready_o = (state_q == IDLE) & ~rst_i;
    assign busy_o       = (state_q != IDLE);
    assign byte_data_o  = byte_data_q;
    assign byte_valid_o = byte_valid_q;

endmodule

// File: tb/tb_is_uart_hex_word_tx.sv
// Directed bench for the hex word printer: scoreboarded byte stream on the 32-bit
// default instance, plus a narrow 8-bit instance without prefix or line ending.
module tb_is_uart_hex_word_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [31:0] word32 = '0;
    logic        wv32 = 1'b0, wr32, bv32, br32 = 1'b0, busy32;
    logic [7:0]  bd32;

    logic [7:0]  word8 = '0;
    logic        wv8 = 1'b0, wr8, bv8, br8 = 1'b0, busy8;
    logic [7:0]  bd8;

    int unsigned n_checks = 0, n_pass = 0, n_fail = 0;
    int unsigned cyc = 0, xfer32 = 0;
    logic [7:0]  q32[$];
    bit          stall_prev = 1'b0;
    logic [7:0]  data_prev = '0;

    is_uart_hex_word_tx dut32 (
        .clk_i(clk), .rst_i(rst), .word_i(word32), .word_valid_i(wv32),
        .word_ready_o(wr32), .byte_data_o(bd32), .byte_valid_o(bv32),
        .byte_ready_i(br32), .busy_o(busy32)
    );

    is_uart_hex_word_tx #(.WORD_W(8), .PREFIX_EN(1'b0), .EOL_EN(1'b0)) dut8 (
        .clk_i(clk), .rst_i(rst), .word_i(word8), .word_valid_i(wv8),
        .word_ready_o(wr8), .byte_data_o(bd8), .byte_valid_o(bv8),
        .byte_ready_i(br8), .busy_o(busy8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    task automatic push_frame(input logic [31:0] w);
        q32.push_back(8'h30);
        q32.push_back(8'h78);
        for (int i = 7; i >= 0; i--) q32.push_back(hex_char(w[i*4 +: 4]));
        q32.push_back(8'h0D);
        q32.push_back(8'h0A);
    endtask

    // Present a word until accepted; returns at posedge+1 of the accepting edge.
    task automatic send32(input logic [31:0] w, input bit push);
        bit ok = 1'b0;
        if (push) push_frame(w);
        word32 = w;
        wv32   = 1'b1;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (wr32) ok = 1'b1;
        end
        @(posedge clk);
        #1 wv32 = 1'b0;
        if (!ok) check("accept_timeout", ok, 1);
    endtask

    task automatic drain32(input int max_cyc);
        for (int i = 0; i < max_cyc && q32.size() != 0; i++) @(posedge clk);
        check("drain_empty", q32.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: pops on every transfer, checks stability while stalled.
    always @(negedge clk) begin
        logic [7:0] exp;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_hold_valid", bv32, 1);
                check("stall_hold_data", bd32, data_prev);
            end
            if (bv32 && br32) begin
                if (q32.size() == 0) begin
                    check("unexpected_byte", q32.size(), 1);
                end else begin
                    exp = q32.pop_front();
                    check("byte", bd32, exp);
                end
                xfer32++;
            end
            stall_prev = bv32 && !br32;
            data_prev  = bd32;
        end
    end

    initial begin
        int unsigned base;
        int unsigned acc[3];
        logic [31:0] words[3];
        bit ok;

        // Reset state
        #2;
        check("rst_valid", bv32, 0);
        check("rst_data", bd32, 0);
        check("rst_busy", busy32, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_ready32", wr32, 1);
        check("post_rst_ready8", wr8, 1);
        check("post_rst_busy", busy32, 0);

        // 1: DEADBEEF, ready high, one byte per cycle then idle
        br32 = 1'b1;
        send32(32'hDEADBEEF, 1'b1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("t1_consecutive_valid", bv32, 1);
        end
        @(negedge clk);
        check("t1_busy_done", busy32, 0);
        check("t1_valid_done", bv32, 0);
        check("t1_sb_empty", q32.size(), 0);
        @(posedge clk);
        #1;

        // 2: all-zero word and ascending digits
        send32(32'h0000_0000, 1'b1);
        drain32(50);
        send32(32'h0123_4567, 1'b1);
        drain32(50);

        // 3: random stalls, 100 random words
        ok = 1'b0;
        fork
            begin
                for (int k = 0; k < 100; k++) send32($urandom(), 1'b1);
                ok = 1'b1;
            end
            begin
                while (!ok) begin
                    @(posedge clk);
                    #1 br32 = 1'($urandom_range(0, 1));
                end
            end
        join
        br32 = 1'b1;
        drain32(200);

        // 4: narrow instance, no prefix / line ending
        br8 = 1'b1;
        word8 = 8'hA5;
        wv8 = 1'b1;
        @(negedge clk);
        check("t4_ready_before", wr8, 1);
        @(posedge clk);
        #1 wv8 = 1'b0;
        @(negedge clk);
        check("t4_b0_valid", bv8, 1);
        check("t4_b0_data", bd8, 8'h41);
        @(negedge clk);
        check("t4_b1_valid", bv8, 1);
        check("t4_b1_data", bd8, 8'h35);
        @(negedge clk);
        check("t4_end_valid", bv8, 0);
        check("t4_ready_back", wr8, 1);
        check("t4_busy_done", busy8, 0);
        @(posedge clk);
        #1;

        // 5: word_valid held high over three words
        words[0] = 32'h1111_2222;
        words[1] = 32'h89AB_CDEF;
        words[2] = 32'h7F00_00F7;
        base = xfer32;
        wv32 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            word32 = words[k];
            push_frame(words[k]);
            ok = 1'b0;
            for (int i = 0; i < 100 && !ok; i++) begin
                @(negedge clk);
                if (wr32) ok = 1'b1;
            end
            check("t5_accept_seen", ok, 1);
            check("t5_idle_at_accept", busy32, 0);
            acc[k] = cyc + 1;
            @(posedge clk);
            #1;
        end
        wv32 = 1'b0;
        drain32(100);
        check("t5_gap01", acc[1] - acc[0], 13);
        check("t5_gap12", acc[2] - acc[1], 13);
        check("t5_total_bytes", xfer32 - base, 36);

        // 6: reset after the fifth byte of CAFEF00D, then a clean frame
        q32.push_back(8'h30);
        q32.push_back(8'h78);
        q32.push_back(8'h43);
        q32.push_back(8'h41);
        q32.push_back(8'h46);
        base = xfer32;
        send32(32'hCAFEF00D, 1'b0);
        for (int i = 0; i < 50 && (xfer32 - base) < 5; i++) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("t6_async_valid", bv32, 0);
        check("t6_async_data", bd32, 0);
        check("t6_async_busy", busy32, 0);
        check("t6_partial_consumed", q32.size(), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("t6_clean_idle", bv32, 0);
        send32(32'h0000_0001, 1'b1);
        drain32(50);
        check("t6_final_busy", busy32, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
